// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port 64-bit backing memory between instruction fetch and data access.
// Handshake: a requester holds x_req until its one-cycle x_valid; m_req is held until the one-cycle m_ack.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              timeout_err,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [SW-1:0]     starve_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              grant_d;
  logic              busy_done;
  logic [DATA_W-1:0] cap;

  // Data has priority unless fetch has already been passed over STARVE_MAX times.
  assign grant_d   = d_req && (!if_req || (starve_cnt != SW'(STARVE_MAX)));
  assign busy_done = m_ack || (tmo_cnt == TW'(TIMEOUT - 1));
  assign cap       = m_ack ? m_rdata : '0;

  // Stalls are gated by reset so they drop at once when resetl falls.
  assign if_stall  = resetl & if_req & ~if_valid;
  assign d_stall   = resetl & d_req & ~d_valid;
  assign fsm_state = state;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      if_valid    <= 1'b0;
      if_rdata    <= '0;
      d_valid     <= 1'b0;
      d_rdata     <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (grant_d) begin
            state   <= BUSY_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + SW'(1);
          end else if (if_req) begin
            state      <= BUSY_I;
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= if_addr;
            m_wdata    <= '0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (busy_done) begin
            m_req <= 1'b0;
            if (!m_ack) timeout_err <= 1'b1;
            if (state == BUSY_I) begin
              // m_addr still holds the fetch address registered at grant.
              if_rdata <= m_addr[2] ? cap[63:32] : cap[31:0];
              if_valid <= 1'b1;
              state    <= RESP_I;
            end else begin
              if (!m_we) d_rdata <= cap;
              d_valid <= 1'b1;
              state   <= RESP_D;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RESP_I, RESP_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port 64-bit backing memory between the pipeline's instruction-fetch (IF) port and its data-access (MEM) port.
- Arbitrates between the two requesters, sequences the memory handshake, and returns read data.
- Generates per-port stall signals for the hazard/pipeline-control logic.
- Sits between the pipeline stages and the memory model inside the processor top level.

Parameters:
ADDR_W, 64, address width of all ports
DATA_W, 64, data width of data port and backing memory
STARVE_MAX, 4, consecutive data grants allowed while a fetch waits, before fetch is forced
TIMEOUT, 255, cycles waiting for m_ack before a transaction is aborted

Ports:
CLK  input  1  system clock, rising-edge
resetl  input  1  asynchronous active-low reset
if_req  input  1  fetch request, level, held until if_valid
if_addr  input  ADDR_W  fetch byte address, stable while if_req
if_valid  output  1  one-cycle pulse: if_rdata valid, request done
if_rdata  output  32  fetched instruction
if_stall  output  1  if_req & ~if_valid
d_req  input  1  data request, level, held until d_valid
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data byte address
d_wdata  input  DATA_W  write data
d_valid  output  1  one-cycle completion pulse
d_rdata  output  DATA_W  read data
d_stall  output  1  d_req & ~d_valid
m_req  output  1  memory request, held until m_ack
m_we  output  1  memory write enable
m_addr  output  ADDR_W  memory address
m_wdata  output  DATA_W  memory write data
m_ack  input  1  memory completion, one cycle
m_rdata  input  DATA_W  memory read data, valid with m_ack
timeout_err  output  1  sticky: a transaction timed out

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-low (resetl).
- Reset forces all outputs to 0, state IDLE, and clears the starve counter, timeout counter and timeout_err. m_req drops immediately on resetl low, including mid-transaction. The memory model must tolerate an abandoned request.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE, arbitration each cycle:
  - Only one requester active -> that requester wins.
  - Both active -> data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - Winner's address, we and wdata are registered onto m_addr/m_we/m_wdata. m_req=1 from the next cycle; state BUSY_x.
  - Fetch always uses m_we=0.
- starve_cnt:
  - Increments on each data grant made while if_req=1.
  - Clears on a fetch grant, or at any arbitration where if_req=0.
  - Saturates at STARVE_MAX.
- BUSY_x:
  - m_req and m_* held stable. Timeout counter increments each cycle.
  - On m_ack: m_req=0 next cycle; m_rdata captured; -> RESP_x.
  - Counter reaching TIMEOUT with no m_ack: m_req=0, timeout_err=1, captured data = 0, -> RESP_x.
- RESP_x:
  - x_valid=1 for exactly one cycle, then -> IDLE.
  - No new arbitration in RESP, so back-to-back transactions are spaced one cycle apart.
- Minimum latency: request seen in IDLE at cycle 0 -> m_req at cycle 1 -> m_ack at cycle 1 -> valid at cycle 2.
- if_rdata = if_addr[2] ? captured[63:32] : captured[31:0], using the address registered at grant.
- d_rdata:
  - Updated only on read completions.
  - Holds its previous value on writes and while idle.
  - if_rdata likewise holds between fetches.
- Request withdrawn after grant: the memory transaction completes normally and the valid pulse still fires; the requester ignores it.
- A new request is accepted only in IDLE. Requests arriving during BUSY/RESP wait and stall.
- m_ack while not in BUSY: ignored.
- timeout_err clears only on reset.

Test Plan:
- Single fetch: if_req=1, if_addr=0x4, memory acks in 1 cycle with m_rdata=0xDEADBEEF_12345678 -> m_req cycle 1 only, if_valid cycle 2, if_rdata=0xDEADBEEF, if_stall=1 cycles 0–1.
- Data write then read:
  - Write d_we=1, d_addr=0x20, d_wdata=0x123456789ABCDEF0 -> m_we=1, m_wdata matches, d_valid pulse, d_rdata unchanged.
  - Read 0x20 (memory returns the written value) -> d_rdata=0x123456789ABCDEF0.
- Contention and starvation: if_req and d_req held high continuously, 1-cycle acks -> grant order D,D,D,D,I,D,D,D,D,I; no fetch waits more than STARVE_MAX data grants.
- Variable latency: m_ack delayed 5 cycles -> m_req and m_addr stable all 5 cycles, valid pulse 1 cycle after ack, stall high throughout.
- Timeout: m_ack never asserted -> after 255 busy cycles m_req=0, timeout_err=1, valid pulse with d_rdata=0; next request still serviced, timeout_err stays 1.
- Reset mid-transaction: resetl=0 during BUSY_D -> m_req, valids and stalls 0 immediately; after release, a fresh if_req completes normally.
